// File: rtl/sub_serial_seq_pkg.sv
// Shared ALU definitions: nibble width and the serial subtract sequencer states.
package sub_serial_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/substractor_4bit.sv
// Gate-level 4-bit ripple subtractor: diff = a - b - bin, bout = borrow out of bit 3.
module substractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] chain;

  assign chain[0] = bin;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_fs
      logic axb;
      assign axb           = a[gi] ^ b[gi];
      assign diff[gi]      = axb ^ chain[gi];
      // Borrow when a<b at this bit, or when equal and a borrow ripples in.
      assign chain[gi + 1] = (~a[gi] & b[gi]) | (~axb & chain[gi]);
    end
  endgenerate

  assign bout = chain[4];

endmodule

// File: rtl/sub_serial_seq.sv
// Serial WIDTH-bit subtractor: reuses one 4-bit subtractor, LSB nibble first,
// chaining the borrow through a register between nibble steps.
module sub_serial_seq
  import sub_serial_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_op1,
  input  logic [WIDTH-1:0] i_op2,
  input  logic             i_borrow,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sub,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_ovf
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  state_t              state_reg, state_next;
  logic [WIDTH-1:0]    op1_reg, op2_reg, sub_reg, sub_next;
  logic                borrow_reg, zero_reg, ovf_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_d;
  logic                nib_bout;
  logic                accept, last_step;

  assign accept    = (state_reg == IDLE) && i_valid;
  assign last_step = (state_reg == RUN) && (cnt_reg == LAST);

  // Select the operand nibbles addressed by the step counter.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (cnt_reg == CNT_W'(i)) begin
        nib_a = op1_reg[i*NIBBLE_W +: NIBBLE_W];
        nib_b = op2_reg[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  substractor_4bit u_sub (
    .a    (nib_a),
    .b    (nib_b),
    .bin  (borrow_reg),
    .diff (nib_d),
    .bout (nib_bout)
  );

  // Merge the fresh nibble into the result; other nibbles keep their value.
  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_res
      assign sub_next[gi*NIBBLE_W +: NIBBLE_W] =
        ((state_reg == RUN) && (cnt_reg == CNT_W'(gi))) ? nib_d
                                                         : sub_reg[gi*NIBBLE_W +: NIBBLE_W];
    end
  endgenerate

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    o_ready    = 1'b0;
    o_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_next = RUN;
      end
      RUN: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        o_valid = 1'b1;
        if (i_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, operand latch, nibble step and final flag capture.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      op1_reg    <= '0;
      op2_reg    <= '0;
      sub_reg    <= '0;
      borrow_reg <= 1'b0;
      zero_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op1_reg    <= i_op1;
        op2_reg    <= i_op2;
        borrow_reg <= i_borrow;
        cnt_reg    <= '0;
      end else if (state_reg == RUN) begin
        sub_reg    <= sub_next;
        borrow_reg <= nib_bout;
        if (last_step) begin
          // Flags look at the fully assembled result, so use sub_next here.
          zero_reg <= (sub_next == '0);
          ovf_reg  <= (op1_reg[WIDTH-1] != op2_reg[WIDTH-1]) &&
                      (sub_next[WIDTH-1] != op1_reg[WIDTH-1]);
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign o_sub    = sub_reg;
  assign o_borrow = borrow_reg;
  assign o_zero   = zero_reg;
  assign o_ovf    = ovf_reg;

endmodule

// File: tb/tb_sub_serial_seq.sv
// Bench for sub_serial_seq: a 16-bit and a 4-bit instance share clock and reset;
// expected results are queued at stimulus time and popped on each output handshake.
module tb_sub_serial_seq;

  logic        clk;
  logic        rst;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;

  logic        valid16, ordy16, bin16, ovalid16, rdy16, bout16, zero16, ovf16;
  logic [15:0] op1_16, op2_16, sub16;
  logic        valid4, ordy4, bin4, ovalid4, rdy4, bout4, zero4, ovf4;
  logic [3:0]  op1_4, op2_4, sub4;

  logic        rand_ready;
  logic        force_ready;

  logic [18:0] q16[$];
  logic [6:0]  q4[$];
  logic [18:0] e16;
  logic [6:0]  e4;

  sub_serial_seq #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid16), .o_ready(ordy16),
    .i_op1(op1_16), .i_op2(op2_16), .i_borrow(bin16), .o_valid(ovalid16),
    .i_ready(rdy16), .o_sub(sub16), .o_borrow(bout16), .o_zero(zero16), .o_ovf(ovf16)
  );

  sub_serial_seq #(.WIDTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid4), .o_ready(ordy4),
    .i_op1(op1_4), .i_op2(op2_4), .i_borrow(bin4), .o_valid(ovalid4),
    .i_ready(rdy4), .o_sub(sub4), .o_borrow(bout4), .o_zero(zero4), .o_ovf(ovf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Golden models: {ovf, zero, borrow, sub}.
  function automatic logic [18:0] model16(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b} - {16'd0, c};
    return {(a[15] != b[15]) && (r[15] != a[15]), r[15:0] == 16'h0, r[16], r[15:0]};
  endfunction

  function automatic logic [6:0] model4(input logic [3:0] a, input logic [3:0] b, input logic c);
    logic [4:0] r;
    r = {1'b0, a} - {1'b0, b} - {4'd0, c};
    return {(a[3] != b[3]) && (r[3] != a[3]), r[3:0] == 4'h0, r[4], r[3:0]};
  endfunction

  // Downstream ready generation and scoreboard check on every output handshake.
  always begin
    @(negedge clk);
    #1;
    if (rand_ready) begin
      rdy16 = ($urandom_range(0, 3) != 0);
      rdy4  = ($urandom_range(0, 3) != 0);
    end else begin
      rdy16 = force_ready;
      rdy4  = force_ready;
    end
    if (!rst && ovalid16 && rdy16) begin
      tests_run++;
      if (q16.size() == 0) begin
        tests_failed++;
        $display("FAIL out16_unexpected: result sub=%h with empty scoreboard", sub16);
      end else begin
        e16 = q16.pop_front();
        if ({ovf16, zero16, bout16, sub16} !== e16)
          begin
            tests_failed++;
            $display("FAIL out16 got ovf=%b zero=%b borrow=%b sub=%h, required ovf=%b zero=%b borrow=%b sub=%h",
                     ovf16, zero16, bout16, sub16, e16[18], e16[17], e16[16], e16[15:0]);
          end
      end
    end
    if (!rst && ovalid4 && rdy4) begin
      tests_run++;
      if (q4.size() == 0) begin
        tests_failed++;
        $display("FAIL out4_unexpected: result sub=%h with empty scoreboard", sub4);
      end else begin
        e4 = q4.pop_front();
        if ({ovf4, zero4, bout4, sub4} !== e4)
          begin
            tests_failed++;
            $display("FAIL out4 got ovf=%b zero=%b borrow=%b sub=%h, required ovf=%b zero=%b borrow=%b sub=%h",
                     ovf4, zero4, bout4, sub4, e4[6], e4[5], e4[4], e4[3:0]);
          end
      end
    end
  end

  // Drive one operand set into the 16-bit instance; returns at the negedge after accept.
  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic c, output int acc_cyc);
    int budget;
    budget = 200;
    op1_16 = a; op2_16 = b; bin16 = c; valid16 = 1'b1;
    while (!ordy16 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL accept16_timeout: o_ready=%b, required 1", ordy16);
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    $display("[TB] sent16 op1=%h op2=%h borrow=%b", a, b, c);
    valid16 = 1'b0; op1_16 = 16'($urandom); op2_16 = 16'($urandom); bin16 = 1'($urandom);
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int budget;
    budget = 200;
    op1_4 = a; op2_4 = b; bin4 = c; valid4 = 1'b1;
    while (!ordy4 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      tests_run++; tests_failed++;
      $display("FAIL accept4_timeout: o_ready=%b, required 1", ordy4);
    end
    @(posedge clk);
    @(negedge clk);
    valid4 = 1'b0; op1_4 = 4'($urandom); op2_4 = 4'($urandom); bin4 = 1'($urandom);
  endtask

  task automatic wait_drain();
    int budget;
    budget = 3000;
    while ((q16.size() != 0 || q4.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    tests_run++;
    if (budget == 0) begin
      tests_failed++;
      $display("FAIL drain_timeout: pending16=%0d pending4=%0d, required 0", q16.size(), q4.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({ovalid16, sub16, bout16, zero16, ovf16} !== 20'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs got valid=%b sub=%h borrow=%b zero=%b ovf=%b, required all 0",
               ovalid16, sub16, bout16, zero16, ovf16);
    end
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (ordy16 !== 1'b1 || ordy4 !== 1'b1 || ovalid4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready got ready16=%b ready4=%b valid4=%b, required 1 1 0", ordy16, ordy4, ovalid4);
    end
  endtask

  task automatic test_latency();
    int acc;
    int c;
    force_ready = 1'b1;
    q16.push_back({1'b0, 1'b0, 1'b0, 16'h1000});
    send16(16'h1234, 16'h0234, 1'b0, acc);
    c = 1;
    while (!ovalid16 && c < 20) begin
      @(negedge clk);
      c++;
    end
    tests_run++;
    if (c != 5) begin
      tests_failed++;
      $display("FAIL latency got o_valid at cycle %0d, required 5", c);
    end
    tests_run++;
    if (sub16 !== 16'h1000) begin
      tests_failed++;
      $display("FAIL latency_sub got %h, required 1000", sub16);
    end
    wait_drain();
  endtask

  task automatic test_borrow();
    int acc;
    q16.push_back({1'b0, 1'b0, 1'b1, 16'hFFFF});
    send16(16'h0000, 16'h0001, 1'b0, acc);
    q16.push_back({1'b0, 1'b0, 1'b1, 16'hFFFF});
    send16(16'h0005, 16'h0005, 1'b1, acc);
    wait_drain();
  endtask

  task automatic test_ovf_zero();
    int acc;
    q16.push_back({1'b1, 1'b0, 1'b0, 16'h7FFF});
    send16(16'h8000, 16'h0001, 1'b0, acc);
    q16.push_back({1'b0, 1'b1, 1'b0, 16'h0000});
    send16(16'h4321, 16'h4321, 1'b0, acc);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int acc_a;
    int acc_b;
    force_ready = 1'b1;
    q16.push_back({1'b0, 1'b0, 1'b0, 16'h00FE});
    send16(16'h00FF, 16'h0001, 1'b0, acc_a);
    q16.push_back({1'b0, 1'b0, 1'b0, 16'h0F00});
    send16(16'h1000, 16'h00FF, 1'b1, acc_b);
    tests_run++;
    if (acc_b - acc_a != 6) begin
      tests_failed++;
      $display("FAIL throughput got %0d cycles between accepts, required 6", acc_b - acc_a);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    int acc;
    int c;
    logic [18:0] snap;
    force_ready = 1'b0;
    q16.push_back({1'b0, 1'b0, 1'b0, 16'h8887});
    send16(16'h9ABC, 16'h1234, 1'b1, acc);
    c = 0;
    while (!ovalid16 && c < 20) begin
      @(negedge clk);
      c++;
    end
    snap = {ovf16, zero16, bout16, sub16};
    op1_16 = 16'h0F0F; op2_16 = 16'h0101; bin16 = 1'b0; valid16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++;
      if (ovalid16 !== 1'b1 || ordy16 !== 1'b0 || {ovf16, zero16, bout16, sub16} !== snap) begin
        tests_failed++;
        $display("FAIL backpressure_hold cyc%0d got valid=%b ready=%b out=%h, required 1 0 %h",
                 i, ovalid16, ordy16, {ovf16, zero16, bout16, sub16}, snap);
      end
    end
    q16.push_back({1'b0, 1'b0, 1'b0, 16'h0E0E});
    force_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (ordy16 !== 1'b1 || ovalid16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL backpressure_release got ready=%b valid=%b, required 1 0", ordy16, ovalid16);
    end
    @(negedge clk);
    tests_run++;
    if (ordy16 !== 1'b0) begin
      tests_failed++;
      $display("FAIL fresh_accept got ready=%b, required 0", ordy16);
    end
    valid16 = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_abort();
    int acc;
    force_ready = 1'b1;
    send16(16'h0000, 16'h0001, 1'b0, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (ovalid16 !== 1'b0 || sub16 !== 16'h0 || ordy16 !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_abort got valid=%b sub=%h ready=%b, required 0 0000 1", ovalid16, sub16, ordy16);
    end
    q16.push_back({1'b0, 1'b0, 1'b0, 16'h0010});
    send16(16'h0010, 16'h0000, 1'b0, acc);
    wait_drain();
  endtask

  task automatic test_random16();
    int acc;
    logic [15:0] a;
    logic [15:0] b;
    logic c;
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if (i == 0) begin a = 16'hFFFF; b = 16'h0000; end
      if (i == 1) begin a = 16'h0000; b = 16'hFFFF; c = 1'b1; end
      if (i == 2) begin a = 16'h7FFF; b = 16'hFFFF; end
      q16.push_back(model16(a, b, c));
      send16(a, b, c, acc);
    end
    wait_drain();
    rand_ready = 1'b0;
  endtask

  task automatic test_exhaustive4();
    logic [3:0] a;
    logic [3:0] b;
    rand_ready = 1'b1;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a = 4'(ia);
          b = 4'(ib);
          q4.push_back(model4(a, b, 1'(ic)));
          send4(a, b, 1'(ic));
        end
      end
    end
    $display("[TB] sent4 exhaustive set of 512 operand triples");
    wait_drain();
    rand_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    valid16 = 1'b0; op1_16 = '0; op2_16 = '0; bin16 = 1'b0;
    valid4 = 1'b0; op1_4 = '0; op2_4 = '0; bin4 = 1'b0;
    rdy16 = 1'b1; rdy4 = 1'b1;
    rand_ready = 1'b0;
    force_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_borrow();
    test_ovf_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    test_random16();
    test_exhaustive4();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sub_serial_seq.md
Name: sub_serial_seq

Overview:
- Multi-word subtract sequencer that drives the existing 4-bit gate-level subtractor (substractor_4bit) one nibble per clock, LSB nibble first.
- Chains the borrow between nibbles in a register, so one 4-bit datapath computes a WIDTH-bit op1 - op2 - borrow.
- Sits between the ALU operand/opcode stage (upstream valid/ready) and the ALU result mux (downstream valid/ready).

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived: number of nibble steps. Not overridable.

Ports:
- i_clk  in  1  clock; all logic on its rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  upstream: operands valid.
- o_ready  out  1  upstream: block can accept an operand set.
- i_op1  in  WIDTH  minuend.
- i_op2  in  WIDTH  subtrahend.
- i_borrow  in  1  borrow-in for the LSB nibble.
- o_valid  out  1  downstream: result valid.
- i_ready  in  1  downstream: result consumed.
- o_sub  out  WIDTH  difference: (i_op1 - i_op2 - i_borrow) mod 2^WIDTH.
- o_borrow  out  1  borrow out of the MSB nibble.
- o_zero  out  1  o_sub == 0.
- o_ovf  out  1  signed overflow.

Behaviour:
- Reset: when i_rst is sampled high, all outputs and internal registers clear (o_sub=0, o_borrow=0, o_zero=0, o_ovf=0, o_valid=0) and the state goes to IDLE. o_ready=1 from the first cycle after reset.
- Reset in RUN or DONE aborts the operation; the partial result is discarded.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On i_valid & o_ready: latch i_op1, i_op2 and i_borrow; clear the nibble counter to 0; go to RUN.
- RUN:
  - o_ready=0 and o_valid=0.
  - Each cycle, the sub-module receives nibble k of op1 and op2 plus the borrow register. k is the counter; the borrow register is loaded with i_borrow at accept.
  - Each cycle, write o_sub nibble k into the result register, load the sub-module borrow-out into the borrow register, and increment k.
  - After nibble NIBBLES-1 is written, go to DONE.
- DONE:
  - o_valid=1. o_sub, o_borrow, o_zero and o_ovf are registered and stay stable until the handshake completes.
  - On i_valid & o_ready... (not applicable: o_ready=0 here); on o_valid & i_ready, go to IDLE.
- Latency: accept edge at cycle 0; o_valid=1 from cycle NIBBLES+1. With WIDTH=16, o_valid is high 5 cycles after accept.
- Throughput: one operation per NIBBLES+2 cycles at best. There is no same-cycle accept while leaving DONE.
- i_valid while busy: ignored because o_ready=0. Upstream must hold i_valid and its operands until accepted.
- Back-pressure: while DONE and i_ready=0, outputs hold indefinitely.
- o_borrow: 1 exactly when op1 < op2 + i_borrow (unsigned).
- o_ovf: 1 exactly when (op1[MSB] != op2[MSB]) and (o_sub[MSB] != op1[MSB]).
- o_zero: computed on the full assembled result at entry to DONE.
- WIDTH=4 degenerates to one RUN cycle.
- Nibble counter width: max(1, clog2(NIBBLES)). No wrap-around occurs inside RUN.
- Operand registers hold the latched values, so upstream may change i_op1/i_op2 right after accept.

Decomposition:
- Shared ALU package holds:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - NIBBLE_W=4.
- One sub-module: substractor_4bit (the existing gate-level 4-bit subtractor), instantiated once and reused across nibbles.
- Counter, operand/result registers and flags stay in the top.

Test Plan:
- WIDTH=16, op1=0x1234, op2=0x0234, borrow=0, i_ready=1 -> o_valid 5 cycles after accept with o_sub=0x1000, o_borrow=0, o_zero=0, o_ovf=0.
- op1=0x0000, op2=0x0001, borrow=0 -> o_sub=0xFFFF, o_borrow=1, o_ovf=0. Then op1=0x0005, op2=0x0005, borrow=1 -> o_sub=0xFFFF, o_borrow=1.
- op1=0x8000, op2=0x0001 -> o_sub=0x7FFF, o_ovf=1, o_borrow=0. Then op1=0x4321, op2=0x4321, borrow=0 -> o_sub=0, o_zero=1.
- Back-pressure: hold i_ready=0 for 6 cycles in DONE while i_valid=1 with new operands -> outputs stable, o_ready=0, no second accept. Set i_ready=1 -> IDLE, then a fresh accept the next cycle.
- Assert i_rst at the 2nd RUN cycle -> the next cycle shows o_valid=0, o_sub=0, o_ready=1. The next operation computes correctly with no stale borrow.
- Self-checking random sweep at WIDTH=16 and WIDTH=4 (exhaustive at 4: all op1, op2, borrow) against golden {borrow, sub} = op1 - op2 - borrow, with a random i_ready pattern -> error_count=0.
